// File: rtl/data_bus_pkg.sv
// Shared size encodings and FSM states for the data bus
// responder and its requester.
package data_bus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/byte_lane_ram.sv
// Word-wide storage with per-byte write enables and a
// registered read port that holds until the next read.
module byte_lane_ram #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [3:0]                     we,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] index,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[index];
  end

endmodule

// File: rtl/data_bus_responder.sv
// Memory-mapped data bus slave: fixed-latency byte/half/word
// accesses with alignment and dual-request error reporting.
module data_bus_responder
  import data_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           store,
  input  logic                           load,
  input  logic [2:0]                     data_type,
  input  logic [$clog2(DEPTH_WORDS)+1:0] address,
  input  logic [31:0]                    write_data,
  output logic [31:0]                    read_data,
  output logic                           ready,
  output logic                           error,
  output logic                           busy
);

  localparam int AW = $clog2(DEPTH_WORDS) + 2;

  state_t state, next;
  logic [3:0] cnt, cnt_next;

  logic [AW-1:0] lat_addr;
  logic [1:0]    lat_size;
  logic [31:0]   lat_wdata;
  logic          lat_store;
  logic          lat_dual;

  logic          idle;
  logic [AW-1:0] cur_addr;
  logic [1:0]    cur_size;
  logic [31:0]   cur_wdata;
  logic          cur_store;
  logic          cur_dual;
  logic [3:0]    mask;
  logic          misalign;
  logic          bad;
  logic          enter_done;
  logic [3:0]    ram_we;
  logic          ram_re;
  logic          unused_sign;

  assign unused_sign = data_type[2];
  assign idle = state == S_IDLE;

  // With WAIT_STATES=0 the access completes on the accepting edge,
  // so the live inputs stand in for the not-yet-latched fields.
  assign cur_addr  = idle ? address         : lat_addr;
  assign cur_size  = idle ? data_type[1:0]  : lat_size;
  assign cur_wdata = idle ? write_data      : lat_wdata;
  assign cur_store = idle ? store           : lat_store;
  assign cur_dual  = idle ? (load & store)  : lat_dual;

  always_comb begin
    mask = 4'b0000;
    unique case (1'b1)
      cur_size[1]:                 mask = 4'b1111;
      !cur_size[1] && cur_size[0]: mask = 4'b0011 << cur_addr[1:0];
      default:                     mask = 4'b0001 << cur_addr[1:0];
    endcase
  end

  assign misalign = (cur_size == SIZE_HALF && cur_addr[0]) ||
                    (cur_size[1] && cur_addr[1:0] != 2'b00);
  assign bad = misalign | cur_dual;

  assign enter_done = next == S_DONE && state != S_DONE && !reset;
  assign ram_we = (enter_done && cur_store && !bad) ? mask : 4'b0000;
  assign ram_re = enter_done && !cur_store && !bad;

  always_comb begin
    next     = state;
    cnt_next = cnt;
    unique case (state)
      S_IDLE: begin
        if (load | store) begin
          if (WAIT_STATES == 0) begin
            next = S_DONE;
          end else begin
            next     = S_WAIT;
            cnt_next = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) next = S_DONE;
        else cnt_next = cnt - 4'd1;
      end
      S_DONE:  next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clock) begin
    if (idle && (load | store)) begin
      lat_addr  <= address;
      lat_size  <= data_type[1:0];
      lat_wdata <= write_data;
      lat_store <= store;
      lat_dual  <= load & store;
    end
  end

  byte_lane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clock(clock),
    .reset(reset),
    .we   (ram_we),
    .re   (ram_re),
    .index(cur_addr[AW-1:2]),
    .wdata(cur_wdata),
    .rdata(read_data)
  );

  assign ready = state == S_DONE;
  assign error = ready && bad;
  assign busy  = !idle;

endmodule

// File: tb/tb_data_bus_responder.sv
// Random and directed accesses against a byte-array model, on a
// one-wait-state responder and a zero-wait-state twin.
module tb_data_bus_responder;
  import data_bus_pkg::*;

  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          store;
  logic          load;
  logic [2:0]    data_type;
  logic [AW-1:0] address;
  logic [31:0]   write_data;
  logic [31:0]   read_data, read_data0;
  logic          ready, error, busy;
  logic          ready0, error0, busy0;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mdl [16];
  logic [31:0] last_rd;

  always #5 clock = ~clock;

  data_bus_responder #(
    .DEPTH_WORDS(256),
    .WAIT_STATES(1)
  ) dut (
    .clock(clock), .reset(reset), .store(store), .load(load),
    .data_type(data_type), .address(address),
    .write_data(write_data), .read_data(read_data),
    .ready(ready), .error(error), .busy(busy)
  );

  data_bus_responder #(
    .DEPTH_WORDS(256),
    .WAIT_STATES(0)
  ) dut0 (
    .clock(clock), .reset(reset), .store(store), .load(load),
    .data_type(data_type), .address(address),
    .write_data(write_data), .read_data(read_data0),
    .ready(ready0), .error(error0), .busy(busy0)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic access(input bit ld, input bit st,
                        input logic [2:0] dt,
                        input logic [AW-1:0] ad,
                        input logic [31:0] wd,
                        input bit poke, input bit chk_fast);
    int sz, off, idx, lat, lat0, nr, nr0;
    bit bad;
    logic [31:0] rd, rd0, exp_rd, w;
    logic er, er0;
    sz  = dt[1] ? 4 : (dt[0] ? 2 : 1);
    off = int'(ad[1:0]);
    idx = int'(ad[5:2]);
    bad = (ld && st) || (off % sz != 0);
    lat = 0; lat0 = 0; nr = 0; nr0 = 0;
    rd = '0; rd0 = '0; er = 1'b0; er0 = 1'b0;
    @(negedge clock);
    load = ld; store = st; data_type = dt;
    address = ad; write_data = wd;
    @(posedge clock); #1;
    load = 1'b0; store = 1'b0;
    chk("busy", 32'(busy), 32'd1);
    if (chk_fast) chk("busy0", 32'(busy0), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      if (ready) begin
        nr++;
        if (lat == 0) begin lat = k; rd = read_data; er = error; end
      end
      if (ready0) begin
        nr0++;
        if (lat0 == 0) begin lat0 = k; rd0 = read_data0; er0 = error0; end
      end
      store = poke && k == 1;
      @(posedge clock); #1;
    end
    store = 1'b0;
    exp_rd = last_rd;
    if (ld && !bad) exp_rd = mdl[idx];
    chk("latency", 32'(lat), 32'd2);
    chk("ready_count", 32'(nr), 32'd1);
    chk("error", 32'(er), 32'(bad));
    chk("read_data", rd, exp_rd);
    if (chk_fast) begin
      chk("latency0", 32'(lat0), 32'd1);
      chk("ready_count0", 32'(nr0), 32'd1);
      chk("error0", 32'(er0), 32'(bad));
      chk("read_data0", rd0, exp_rd);
    end
    if (st && !bad) begin
      w = mdl[idx];
      for (int b = off; b < off + sz; b++) w[8*b +: 8] = wd[8*b +: 8];
      mdl[idx] = w;
    end
    if (ld && !bad) last_rd = exp_rd;
  endtask

  initial begin
    int r, nr;
    bit ld, st;
    reset = 1'b1; store = 1'b0; load = 1'b0;
    data_type = '0; address = '0; write_data = '0;
    last_rd = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_read_data0", read_data0, 32'd0);

    for (int i = 0; i < 16; i++)
      access(0, 1, {1'b0, SIZE_WORD}, AW'(i * 4), $urandom, 0, 1);

    access(0, 1, {1'b0, SIZE_WORD}, 10'h010, 32'hDDCCBBAA, 0, 1);
    access(1, 0, {1'b0, SIZE_WORD}, 10'h010, 32'h0, 0, 1);
    chk("word_rd", read_data, 32'hDDCCBBAA);
    access(0, 1, {1'b0, SIZE_BYTE}, 10'h012, 32'h00EE0000, 0, 1);
    access(1, 0, {1'b0, SIZE_WORD}, 10'h010, 32'h0, 0, 1);
    chk("byte_merge_rd", read_data, 32'hDDEEBBAA);
    access(0, 1, {1'b0, SIZE_HALF}, 10'h011, 32'h12345678, 0, 1);
    access(1, 0, {1'b0, SIZE_WORD}, 10'h010, 32'h0, 0, 1);
    chk("misalign_keep", read_data, 32'hDDEEBBAA);
    access(1, 1, {1'b0, SIZE_WORD}, 10'h010, 32'h0BADF00D, 0, 1);
    access(1, 0, {1'b0, SIZE_WORD}, 10'h010, 32'h0, 1, 1);
    access(1, 0, {1'b0, SIZE_WORD}, 10'h010, 32'h0, 0, 1);
    chk("dual_keep", read_data, 32'hDDEEBBAA);

    @(negedge clock);
    store = 1'b1; data_type = {1'b0, SIZE_WORD};
    address = 10'h020; write_data = ~mdl[8];
    @(posedge clock); #1;
    store = 1'b0;
    chk("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_rd", read_data, 32'd0);
    nr = 0;
    for (int k = 0; k < 3; k++) begin
      if (ready) nr++;
      @(posedge clock); #1;
    end
    chk("abort_no_ready", 32'(nr), 32'd0);
    last_rd = '0;
    access(1, 0, {1'b0, SIZE_WORD}, 10'h020, 32'h0, 0, 0);
    access(0, 1, {1'b0, SIZE_WORD}, 10'h020, mdl[8], 0, 0);
    access(1, 0, {1'b0, SIZE_WORD}, 10'h020, 32'h0, 0, 1);

    for (int i = 0; i < 150; i++) begin
      r  = int'($urandom_range(0, 9));
      ld = (r <= 4);
      st = (r == 0) || (r >= 5);
      access(ld, st, 3'($urandom_range(0, 7)),
             AW'($urandom_range(0, 63)), $urandom,
             $urandom_range(0, 7) == 0, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit memory words (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning the number of extra wait cycles per access (0..15).
REQ-003 SHALL have port clock  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port store  input  1  single-cycle write request pulse.
REQ-006 SHALL have port load  input  1  single-cycle read request pulse.
REQ-007 SHALL have port data_type  input  3  access size: [1:0] 00=byte, 01=half, 1x=word; bit 2 (signedness) ignored.
REQ-008 SHALL have port address  input  log2(DEPTH_WORDS)+2  byte address; [1:0] is the lane offset.
REQ-009 SHALL have port write_data  input  32  lane-aligned store data.
REQ-010 SHALL have port read_data  output  32  full registered word; the requester extracts and extends the bytes.
REQ-011 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port error  output  1  one-cycle pulse, coincident with ready, flagging a rejected access.
REQ-013 SHALL have port busy  output  1  high from request acceptance until the ready cycle inclusive.

Function
REQ-014 SHALL implement FSM IDLE -> WAIT -> DONE -> IDLE; WAIT is skipped when WAIT_STATES=0.
REQ-015 SHALL accept a request only in IDLE, latching address, data_type, write_data and direction on that edge.
REQ-016 SHALL ignore load/store pulses while not in IDLE (no queuing).
REQ-017 SHALL count WAIT_STATES cycles in WAIT using a 4-bit down-counter, then enter DONE.
REQ-018 SHALL assert ready (and read_data, for reads) exactly WAIT_STATES+1 cycles after the accepting edge.
REQ-019 SHALL derive byte-lane enables as: byte 4'b0001<<offset, half 4'b0011<<offset, word 4'b1111.
REQ-020 SHALL commit a store on the edge entering DONE, writing only enabled lanes; other lanes keep their contents.
REQ-021 SHALL load read_data with the addressed word on the edge entering DONE and hold it until the next successful load.
REQ-022 SHALL treat as misaligned: half with offset[0]=1, or word with offset!=0 -> error=1 with ready, no write, read_data unchanged.
REQ-023 SHALL treat load and store both high in the same IDLE cycle as an error access: full latency, error=1, no write.
REQ-024 SHALL return to IDLE after DONE, so back-to-back requests may be issued the cycle after ready (minimum 2 cycles apart when WAIT_STATES=0).
REQ-025 SHALL return, for a load following a store to the same word, the newly written data.

Reset
REQ-026 SHALL on reset force the state to IDLE, counter=0, read_data=0, ready=0, error=0 and busy=0 at the next edge.
REQ-027 SHALL abort an access in progress when reset is asserted mid-operation: no memory write and no ready pulse.
REQ-028 SHALL leave memory contents uninitialised and unaffected by reset.

Structure
REQ-029 SHALL take the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the FSM state enum from shared package data_bus_pkg; the requester uses the same size constants.
REQ-030 SHALL hold the storage in sub-module byte_lane_ram: DEPTH_WORDS x 32 bits, 4 byte write enables, synchronous read.
REQ-031 SHALL keep lane-mask and alignment checks combinational inside data_bus_responder.

Verification (WAIT_STATES=1 unless stated)
REQ-032 SHALL cover: store word 0xDDCCBBAA at address 0x010, then load 0x010 -> ready 2 cycles after each request, read_data=0xDDCCBBAA, error=0.
REQ-033 SHALL cover: after REQ-032, store byte (000) to address 0x012 with write_data 0x00EE0000, then word load 0x010 -> read_data=0xDDEEBBAA.
REQ-034 SHALL cover: store half (001) to address 0x011 -> ready with error=1; a word load of 0x010 then returns its previous value unchanged.
REQ-035 SHALL cover: load and store pulsed together -> error=1 with ready, memory unchanged; a store pulse during busy -> ignored, with exactly one ready.
REQ-036 SHALL cover: reset asserted in WAIT during a store -> busy=0 and ready=0 next cycle, and the target word unchanged.
REQ-037 SHALL cover: WAIT_STATES=0 with a word load -> ready 1 cycle after the request.
